// File: rtl/pool_pkg.sv
// Shared types and default sizes for the pool bus arbiter.
// The optional idle-beat timeout is enabled by defining POOL_ARB_TIMEOUT_EN.
package pool_pkg;

    localparam int POOL_ADDR_W  = 28;
    localparam int POOL_LEN_W   = 4;
    localparam int POOL_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_RD   = 3'd2,
        ST_AW   = 3'd3,
        ST_WR   = 3'd4
    } pool_arb_state_t;

endpackage

// File: rtl/pool_arb_rr.sv
// Two-way round-robin picker: remembers which side was served last and,
// on a tie, picks the other one. Resets to "write served last".
module pool_arb_rr
    import pool_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_rd_req,
    input  logic i_wr_req,
    input  logic i_grant,
    output logic o_pick_wr
);

    logic r_last_wr;

    assign o_pick_wr = i_wr_req && (!i_rd_req || !r_last_wr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_wr <= 1'b1;
        end else if (i_grant) begin
            r_last_wr <= o_pick_wr;
        end
    end

endmodule

// File: rtl/pool_bus_arbiter.sv
// Arbitrates the pool read controller and write bridge onto one shared address bus.
// Define POOL_ARB_TIMEOUT_EN to abort data phases that see no beat for TIMEOUT cycles.
//
// Handshake: a transfer happens on a cycle where valid and ready are both high;
// requesters hold valid/addr/len stable until they see ready.
module pool_bus_arbiter
    import pool_pkg::*;
#(
    parameter int ADDR_W  = POOL_ADDR_W,
    parameter int LEN_W   = POOL_LEN_W,
    parameter int TIMEOUT = POOL_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [LEN_W-1:0]  wr_len,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LEN_W-1:0]  m_len,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic              m_awvalid,
    input  logic              m_awready,
    input  logic              m_rvalid,
    input  logic              m_rlast,
    input  logic              m_wready,
    input  logic              m_wlast,
    output logic              link_read,
    output logic              link_write,
    output logic              err,
    output pool_arb_state_t   o_dbg_state
);

    pool_arb_state_t  r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W:0]   r_cnt;
    logic             r_err;
    logic             w_pick_wr;
    logic             w_grant;
    logic             w_beat;
    logic             w_last;

`ifdef POOL_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] r_tmo;
`endif

    assign w_grant = (r_state == ST_IDLE) && (rd_valid || wr_valid);

    pool_arb_rr u_rr (
        .clk      (clk),
        .rst      (rst),
        .i_rd_req (rd_valid),
        .i_wr_req (wr_valid),
        .i_grant  (w_grant),
        .o_pick_wr(w_pick_wr)
    );

    assign w_beat = (r_state == ST_RD) ? m_rvalid : m_wready;
    assign w_last = (r_state == ST_RD) ? m_rlast  : m_wlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
`ifdef POOL_ARB_TIMEOUT_EN
            r_tmo   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state <= w_pick_wr ? ST_AW : ST_AR;
                    end
                end
                ST_AR: begin
                    if (m_arready) begin
                        r_state <= ST_RD;
                        r_len   <= rd_len;
                        r_cnt   <= '0;
`ifdef POOL_ARB_TIMEOUT_EN
                        r_tmo   <= '0;
`endif
                    end
                end
                ST_AW: begin
                    if (m_awready) begin
                        r_state <= ST_WR;
                        r_len   <= wr_len;
                        r_cnt   <= '0;
`ifdef POOL_ARB_TIMEOUT_EN
                        r_tmo   <= '0;
`endif
                    end
                end
                ST_RD, ST_WR: begin
                    // The counter holds the index of the current beat, so a
                    // well-formed last beat arrives with r_cnt == r_len.
                    if (w_beat) begin
                        r_cnt <= r_cnt + 1'b1;
`ifdef POOL_ARB_TIMEOUT_EN
                        r_tmo <= '0;
`endif
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            if (r_cnt != {1'b0, r_len}) begin
                                r_err <= 1'b1;
                            end
                        end
                    end
`ifdef POOL_ARB_TIMEOUT_EN
                    else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        m_addr     = '0;
        m_len      = '0;
        m_arvalid  = 1'b0;
        m_awvalid  = 1'b0;
        rd_ready   = 1'b0;
        wr_ready   = 1'b0;
        link_read  = 1'b0;
        link_write = 1'b0;
        case (r_state)
            ST_AR: begin
                m_arvalid = 1'b1;
                m_addr    = rd_addr;
                m_len     = rd_len;
                rd_ready  = m_arready;
            end
            ST_AW: begin
                m_awvalid = 1'b1;
                m_addr    = wr_addr;
                m_len     = wr_len;
                wr_ready  = m_awready;
            end
            ST_RD:   link_read  = 1'b1;
            ST_WR:   link_write = 1'b1;
            default: ;
        endcase
    end

    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pool_bus_arbiter.sv
// Directed bench for pool_bus_arbiter: a cycle table for single bursts plus
// hand sequences for reset, round-robin alternation and the data-phase timeout.
module tb_pool_bus_arbiter;
  import pool_pkg::*;

  localparam int AW = 28;
  localparam int LW = 4;
`ifdef POOL_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  localparam logic [AW-1:0] RA  = 28'h0000100;
  localparam logic [AW-1:0] WA  = 28'h0002000;
  localparam logic [AW-1:0] RA2 = 28'h0000340;
  localparam logic [AW-1:0] WA2 = 28'h0005580;

  logic clk, rst;
  logic rd_valid, rd_ready, wr_valid, wr_ready;
  logic [AW-1:0] rd_addr, wr_addr, m_addr;
  logic [LW-1:0] rd_len, wr_len, m_len;
  logic m_arvalid, m_arready, m_awvalid, m_awready;
  logic m_rvalid, m_rlast, m_wready, m_wlast;
  logic link_read, link_write, err;
  pool_arb_state_t dbg_state;

  int total = 0;
  int bad = 0;

  pool_bus_arbiter #(.ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_len(rd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_len(wr_len),
    .m_addr(m_addr), .m_len(m_len),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_wready(m_wready), .m_wlast(m_wlast),
    .link_read(link_read), .link_write(link_write), .err(err),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rv;
    logic [AW-1:0] ra;
    logic [LW-1:0] rl;
    logic          wv;
    logic [AW-1:0] wa;
    logic [LW-1:0] wl;
    logic          arr, awr, rvl, rlst, wrd, wlst;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_len;
    logic [5:0]    e_flags;  // {arvalid, awvalid, rd_ready, wr_ready, link_read, link_write}
    logic          e_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] flags();
    return {m_arvalid, m_awvalid, rd_ready, wr_ready, link_read, link_write};
  endfunction

  task automatic clear_inputs();
    rd_valid = 0; rd_addr = '0; rd_len = '0;
    wr_valid = 0; wr_addr = '0; wr_len = '0;
    m_arready = 0; m_awready = 0;
    m_rvalid = 0; m_rlast = 0; m_wready = 0; m_wlast = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    #1;
    check("reset_outputs", 32'({m_addr, m_len, flags(), err}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    rd_valid = v.rv; rd_addr = v.ra; rd_len = v.rl;
    wr_valid = v.wv; wr_addr = v.wa; wr_len = v.wl;
    m_arready = v.arr; m_awready = v.awr;
    m_rvalid = v.rvl; m_rlast = v.rlst; m_wready = v.wrd; m_wlast = v.wlst;
  endtask

  // scoreboard for the round-robin sequence: side (0=read,1=write) and grant cycle
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  initial begin
    rst = 1;
    clear_inputs();

    // read burst len=3 with a gap, then stray beats in IDLE, then a short write burst
    vecs[0]  = '{1, RA, 4'd3, 0, '0, '0, 0, 0, 0, 0, 0, 0, '0, '0,   6'b000000, 0};
    vecs[1]  = '{1, RA, 4'd3, 0, '0, '0, 0, 0, 0, 0, 0, 0, RA, 4'd3, 6'b100000, 0};
    vecs[2]  = '{1, RA, 4'd3, 0, '0, '0, 1, 0, 0, 0, 0, 0, RA, 4'd3, 6'b101000, 0};
    vecs[3]  = '{0, '0, '0,   0, '0, '0, 0, 0, 1, 0, 0, 0, '0, '0,   6'b000010, 0};
    vecs[4]  = '{0, '0, '0,   0, '0, '0, 0, 0, 0, 0, 0, 0, '0, '0,   6'b000010, 0};
    vecs[5]  = '{0, '0, '0,   0, '0, '0, 0, 0, 1, 0, 0, 0, '0, '0,   6'b000010, 0};
    vecs[6]  = '{0, '0, '0,   0, '0, '0, 0, 0, 1, 0, 0, 0, '0, '0,   6'b000010, 0};
    vecs[7]  = '{0, '0, '0,   0, '0, '0, 0, 0, 1, 1, 0, 0, '0, '0,   6'b000010, 0};
    vecs[8]  = '{0, '0, '0,   0, '0, '0, 0, 0, 0, 0, 0, 0, '0, '0,   6'b000000, 0};
    vecs[9]  = '{0, '0, '0,   0, '0, '0, 1, 1, 1, 1, 1, 1, '0, '0,   6'b000000, 0};
    vecs[10] = '{0, '0, '0,   1, WA, 4'd3, 0, 1, 0, 0, 0, 0, '0, '0,   6'b000000, 0};
    vecs[11] = '{0, '0, '0,   1, WA, 4'd3, 0, 1, 0, 0, 0, 0, WA, 4'd3, 6'b010100, 0};
    vecs[12] = '{0, '0, '0,   0, '0, '0, 0, 0, 0, 0, 1, 0, '0, '0,   6'b000001, 0};
    vecs[13] = '{0, '0, '0,   0, '0, '0, 0, 0, 0, 0, 1, 1, '0, '0,   6'b000001, 0};
    vecs[14] = '{0, '0, '0,   0, '0, '0, 0, 0, 0, 0, 0, 0, '0, '0,   6'b000000, 1};
    vecs[15] = '{0, '0, '0,   0, '0, '0, 0, 0, 1, 1, 1, 0, '0, '0,   6'b000000, 1};

    do_reset();

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      apply_vec(vecs[i]);
      #1;
      check($sformatf("vec%0d_addr", i), 32'(m_addr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d_len", i), 32'(m_len), 32'(vecs[i].e_len));
      check($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vecs[i].e_flags));
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].e_err));
    end

    // reset in the middle of a read data phase, with err already set
    @(negedge clk);
    clear_inputs();
    rd_valid = 1; rd_addr = RA; rd_len = 4'd3; m_arready = 1;
    @(negedge clk);
    @(negedge clk);
    rd_valid = 0; m_arready = 0;
    #1;
    check("midrd_link_read", 32'(link_read), 32'd1);
    check("midrd_err_before", 32'(err), 32'd1);
    #2;
    rst = 1;
    #1;
    check("midrd_rst_outputs", 32'({m_addr, m_len, flags(), err}), 32'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    check("midrd_after_state", 32'(dbg_state), 32'(ST_IDLE));
    check("midrd_after_err", 32'(err), 32'd0);

    // both sides request continuously from reset: expect R,W,R,W with one IDLE bubble
    do_reset();
    exp_q = '{8'd0, 8'd1, 8'd1, 8'd4, 8'd0, 8'd7, 8'd1, 8'd10};
    got_q = {};
    @(negedge clk);
    rd_valid = 1; rd_addr = RA2; rd_len = 4'd0;
    wr_valid = 1; wr_addr = WA2; wr_len = 4'd0;
    m_arready = 1; m_awready = 1;
    m_rvalid = 1; m_rlast = 1; m_wready = 1; m_wlast = 1;
    for (int c = 0; c < 40 && got_q.size() < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (m_arvalid) begin
        got_q.push_back(8'd0);
        got_q.push_back(8'(c));
        check($sformatf("rr_rd_addr_c%0d", c), 32'(m_addr), 32'(RA2));
      end else if (m_awvalid) begin
        got_q.push_back(8'd1);
        got_q.push_back(8'(c));
        check($sformatf("rr_wr_addr_c%0d", c), 32'(m_addr), 32'(WA2));
      end
    end
    check("rr_grant_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("rr_%s_%0d", (i % 2 == 0) ? "side" : "cycle", i / 2),
            32'(got_q[i]), 32'(exp_q[i]));
    end
    check("rr_err", 32'(err), 32'd0);

    // read granted but no data beats ever arrive
    do_reset();
    @(negedge clk);
    rd_valid = 1; rd_addr = RA; rd_len = 4'd3; m_arready = 1;
    @(negedge clk);
    #1;
    check("tmo_ar_handshake", 32'(rd_ready), 32'd1);
    begin
      int rd_cycles;
      rd_cycles = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        rd_valid = 0; m_arready = 0;
        #1;
        if (link_read) rd_cycles++;
      end
`ifdef POOL_ARB_TIMEOUT_EN
      check("tmo_rd_cycles", 32'(rd_cycles), 32'(TMO));
      check("tmo_err", 32'(err), 32'd1);
      check("tmo_state", 32'(dbg_state), 32'(ST_IDLE));
`else
      check("notmo_rd_cycles", 32'(rd_cycles), 32'd40);
      check("notmo_err", 32'(err), 32'd0);
      check("notmo_state", 32'(dbg_state), 32'(ST_RD));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
